des_round_sched: RTL and testbench

DES_ROUND_SCHED -- requirements
Module: des_round_sched

---
 rtl/des_pkg.sv | 60 ++++++
 rtl/des_round.sv | 37 +++
 rtl/des_round_sched.sv | 101 ++++++++++
 tb/tb_des_round_sched.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: DES FSM states, key rotation schedules, permutation/S-box tables and round helpers.
// The encrypt schedule exists only when DES_ENCRYPT_EN is defined.
package des_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int ROT_DEC [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
`ifdef DES_ENCRYPT_EN
  localparam int ROT_ENC [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
`endif
  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};
  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};
  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int IPI_TAB [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};
  // Entry n of each box sits at nibble n counted from the MSB (row*16 + column).
  localparam logic [255:0] SBOX [8] = '{
    256'he4d12fb83a6c5907_0f74e2d1a6cb9538_41e8d62bfc973a50_fc8249175b3ea06d,
    256'hf18e6b34972dc05a_3d47f28ec01a69b5_0e7ba4d158c6932f_d8a13f42b67c05e9,
    256'ha09e63f51dc7b428_d709346a285ecbf1_d6498f30b12c5ae7_1ad069874fe3b52c,
    256'h7de3069a1285bc4f_d8b56f03472c1ae9_a690cb7df13e5284_3f06a1d8945bc72e,
    256'h2c417ab6853fd0e9_eb2c47d150fa3986_421bad78f9c5630e_b8c71e2d6f09a453,
    256'hc1af92680d34e75b_af427c9561de0b38_9ef528c3704a1db6_432c95fabe17608d,
    256'h4b2ef08d3c975a61_d0b7491ae35c2f86_14bdc37eaf680592_6bd814a7950fe23c,
    256'hd2846fb1a93e50c7_1fd8a374c56b0e92_7b419ce206adf358_21e74a8dfc90356b};
  // Tables use DES bit numbering: bit 1 is the MSB of the vector.
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] k;
    for (int i = 0; i < 48; i++) k[47-i] = cd[56-PC2_TAB[i]];
    return k;
  endfunction
  function automatic logic [31:0] f_fn(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, p;
    logic [5:0] v;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_TAB[i]] ^ k[47-i];
    for (int i = 0; i < 8; i++) begin
      v = {x[47-6*i], x[42-6*i], x[46-6*i -: 4]};
      s[31-4*i -: 4] = SBOX[i][255-4*v -: 4];
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_TAB[i]];
    return p;
  endfunction
  function automatic logic [63:0] ip_inv(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IPI_TAB[i]];
    return y;
  endfunction
endpackage

// File: rtl/des_round.sv
// des_round: one combinational DES round -- rotate C/D, PC-2 subkey, f-function, L/R swap.
// Ports: c/d/l/r current state, sh rotation amount, enc (DES_ENCRYPT_EN only) selects
// left rotation; c_n/d_n/l_n/r_n next state.
module des_round
  import des_pkg::*;
(
  input  logic [27:0] c,
  input  logic [27:0] d,
  input  logic [31:0] l,
  input  logic [31:0] r,
  input  logic [1:0]  sh,
`ifdef DES_ENCRYPT_EN
  input  logic        enc,
`endif
  output logic [27:0] c_n,
  output logic [27:0] d_n,
  output logic [31:0] l_n,
  output logic [31:0] r_n
);
  logic [55:0] cc, dd;
  // Rotation by shifting a doubled copy: the wrapped bits fall into the kept half.
  always_comb begin
`ifdef DES_ENCRYPT_EN
    cc = enc ? {c, c} << sh : {c, c} >> sh;
    dd = enc ? {d, d} << sh : {d, d} >> sh;
    c_n = enc ? cc[55:28] : cc[27:0];
    d_n = enc ? dd[55:28] : dd[27:0];
`else
    cc = {c, c} >> sh;
    dd = {d, d} >> sh;
    c_n = cc[27:0];
    d_n = dd[27:0];
`endif
    l_n = r;
    r_n = l ^ f_fn(r, pc2({c_n, d_n}));
  end
endmodule

// File: rtl/des_round_sched.sv
// des_round_sched: iterative DES core, ROUNDS_PER_CYC (1/2/4) rounds per clock, valid/ready in and out.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in (IP-permuted block)/key ({D0,C0});
// mode (1=encrypt, DES_ENCRYPT_EN only); out_valid/out_ready/out (IP^-1 result); busy; round_idx.
// Macro DES_ENCRYPT_EN adds the mode port and the encrypt schedule; default build is decrypt-only.
module des_round_sched
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in,
  input  logic [55:0] key,
`ifdef DES_ENCRYPT_EN
  input  logic        mode,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out,
  output logic        busy,
  output logic [3:0]  round_idx
);
  localparam int N = ROUNDS_PER_CYC;
  if (N != 1 && N != 2 && N != 4) begin : g_bad
    $error("des_round_sched: ROUNDS_PER_CYC must be 1, 2 or 4");
  end
  state_t state, state_d;
  logic [31:0] l_q, r_q;
  logic [27:0] c_q, d_q;
  logic [31:0] lc [N+1];
  logic [31:0] rc [N+1];
  logic [27:0] cc [N+1];
  logic [27:0] dc [N+1];
  logic [3:0] idx_n;
  logic accept;
`ifdef DES_ENCRYPT_EN
  logic enc_q;
`endif
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign idx_n = round_idx + 4'(N);
  assign lc[0] = l_q;
  assign rc[0] = r_q;
  assign cc[0] = c_q;
  assign dc[0] = d_q;
  for (genvar g = 0; g < N; g++) begin : g_rnd
    logic [3:0] i;
    assign i = round_idx + 4'(g);
    des_round u_rnd (
      .c(cc[g]),
      .d(dc[g]),
      .l(lc[g]),
      .r(rc[g]),
`ifdef DES_ENCRYPT_EN
      .sh(enc_q ? 2'(ROT_ENC[i]) : 2'(ROT_DEC[i])),
      .enc(enc_q),
`else
      .sh(2'(ROT_DEC[i])),
`endif
      .c_n(cc[g+1]),
      .d_n(dc[g+1]),
      .l_n(lc[g+1]),
      .r_n(rc[g+1])
    );
  end
  // round_idx wrapping to 0 marks the final RUN cycle.
  always_comb state_d = accept ? RUN :
                        (state == RUN && idx_n == 4'd0) ? DONE :
                        (state == DONE && out_ready) ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {l_q, r_q} <= '0;
      {c_q, d_q} <= '0;
      round_idx <= '0;
      out <= '0;
`ifdef DES_ENCRYPT_EN
      enc_q <= 1'b0;
`endif
    end else if (accept) begin
      {l_q, r_q} <= in;
      {d_q, c_q} <= key;
      round_idx <= '0;
`ifdef DES_ENCRYPT_EN
      enc_q <= mode;
`endif
    end else if (state == RUN) begin
      l_q <= lc[N];
      r_q <= rc[N];
      c_q <= cc[N];
      d_q <= dc[N];
      round_idx <= idx_n;
      if (idx_n == 4'd0) out <= ip_inv({rc[N], lc[N]});
    end
endmodule

// File: tb/tb_des_round_sched.sv
// tb_des_round_sched: known-answer and handshake checks of des_round_sched at 1, 2 and 4 rounds per cycle.
module tb_des_round_sched;
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  typedef struct {
    logic [63:0] ct;
    logic [63:0] k;
    logic [63:0] pt;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] blk;
  logic [55:0] key;
`ifdef DES_ENCRYPT_EN
  logic mode;
`endif
  logic [2:0] iv, ordy, ir, ov, bz;
  logic [63:0] o [3];
  logic [3:0] ri [3];
  int checks = 0;
  int errors = 0;
  vec_t v [5];
  int n, last, got, r;
  logic [63:0] res, res2;
  logic seen;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    des_round_sched #(.ROUNDS_PER_CYC(1 << g)) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(iv[g]),
      .in_ready(ir[g]),
      .in(blk),
      .key(key),
`ifdef DES_ENCRYPT_EN
      .mode(mode),
`endif
      .out_valid(ov[g]),
      .out_ready(ordy[g]),
      .out(o[g]),
      .busy(bz[g]),
      .round_idx(ri[g])
    );
  end
  function automatic logic [63:0] ip_f(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction
  // 64-bit DES key -> key port layout {D0, C0}
  function automatic logic [55:0] kmap(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return {y[27:0], y[55:28]};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  // Starts on a negedge in IDLE, returns on the negedge after the result transfer.
  task automatic xfer(input int u, input logic [63:0] b, input logic [55:0] k, output logic [63:0] q);
    int c, rr;
    rr = 1 << u;
    blk = b;
    key = k;
    iv[u] = 1'b1;
    chk("in_ready", 64'(ir[u]), 64'd1);
    @(negedge clk);
    iv[u] = 1'b0;
    blk = ~b;
    key = ~k;
    c = 1;
    while (!ov[u] && c < 40) begin
      chk("run_idx", 64'({bz[u], ri[u]}), 64'({1'b1, 4'((c - 1) * rr)}));
      @(negedge clk);
      c++;
    end
    chk("latency", 64'(c), 64'(16 / rr + 1));
    chk("done_idx", 64'({bz[u], ri[u]}), 64'h10);
    q = o[u];
    ordy[u] = 1'b1;
    @(negedge clk);
    ordy[u] = 1'b0;
    chk("after_xfer", 64'({ov[u], ir[u], bz[u]}), 64'b010);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    v[0] = '{64'h0000000000000000, 64'h0000000000000000, 64'h8CA64DE9C1B123A7};
    v[1] = '{64'h85E813540F0AB405, 64'h133457799BBCDFF1, 64'h0123456789ABCDEF};
    v[2] = '{64'h0000000000000000, 64'h0E329232EA6D0D73, 64'h8787878787878787};
    v[3] = '{64'h7359B2163E4EDC58, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
    v[4] = '{64'h3FA40E8A984D4815, 64'h0123456789ABCDEF, 64'h4E6F772069732074};
    iv = '0;
    ordy = '0;
    blk = '0;
    key = '0;
`ifdef DES_ENCRYPT_EN
    mode = 1'b0;
`endif
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    for (int u = 0; u < 3; u++) begin
      chk("rst_flags", 64'({ov[u], bz[u], ir[u], ri[u]}), 64'b0010000);
      chk("rst_out", o[u], 64'd0);
    end
    for (int i = 0; i < 5; i++)
      for (int u = 0; u < 3; u++) begin
        xfer(u, ip_f(v[i].ct), kmap(v[i].k), res);
        chk("kat", res, v[i].pt);
      end
`ifdef DES_ENCRYPT_EN
    for (int u = 0; u < 3; u++) begin
      mode = 1'b1;
      xfer(u, ip_f(64'h0123456789ABCDEF), kmap(64'h133457799BBCDFF1), res);
      chk("enc_kat", res, 64'h85E813540F0AB405);
      xfer(u, ip_f(64'h0123456789ABCDEF), 56'h13345779ABCDF1, res);
      mode = 1'b0;
      xfer(u, ip_f(res), 56'h13345779ABCDF1, res2);
      chk("roundtrip", res2, 64'h0123456789ABCDEF);
    end
`endif
    blk = ip_f(v[1].ct);
    key = kmap(v[1].k);
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    n = 0;
    while (!ov[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reach", 64'(ov[0]), 64'd1);
    for (int c = 0; c < 10; c++) begin
      iv[0] = c[0];
      blk = {2{32'(c)}};
      key = ~key;
      chk("hold_out", o[0], v[1].pt);
      chk("hold_flags", 64'({ov[0], ir[0], bz[0], ri[0]}), 64'b1010000);
      @(negedge clk);
    end
    blk = ip_f(v[0].ct);
    key = kmap(v[0].k);
    ordy[0] = 1'b1;
    iv[0] = 1'b1;
    @(negedge clk);
    chk("b2b_idle", 64'({ov[0], ir[0], bz[0]}), 64'b010);
    @(negedge clk);
    iv[0] = 1'b0;
    ordy[0] = 1'b0;
    chk("b2b_run", 64'({bz[0], ri[0]}), 64'h10);
    n = 1;
    while (!ov[0] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_lat", 64'(n), 64'd17);
    chk("b2b_out", o[0], v[0].pt);
    ordy[0] = 1'b1;
    @(negedge clk);
    ordy[0] = 1'b0;
    for (int u = 0; u < 3; u += 2) begin
      r = 1 << u;
      blk = ip_f(v[2].ct);
      key = kmap(v[2].k);
      ordy[u] = 1'b1;
      iv[u] = 1'b1;
      n = 0;
      last = -1;
      got = 0;
      while (got < 3 && n < 200) begin
        @(negedge clk);
        n++;
        if (ov[u]) begin
          chk("strm_out", o[u], v[2].pt);
          if (last >= 0) chk("strm_gap", 64'(n - last), 64'(16 / r + 2));
          last = n;
          got++;
        end
      end
      iv[u] = 1'b0;
      chk("strm_cnt", 64'(got), 64'd3);
      @(negedge clk);
      ordy[u] = 1'b0;
      chk("strm_idle", 64'({ov[u], ir[u], bz[u]}), 64'b010);
    end
    blk = ip_f(v[1].ct);
    key = kmap(v[1].k);
    iv[0] = 1'b1;
    iv[2] = 1'b1;
    @(negedge clk);
    iv = '0;
    n = 0;
    while (ri[0] != 4'd5 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_idx", 64'({bz[0], ri[0]}), 64'h15);
    chk("pre_rst_done", 64'(ov[2]), 64'd1);
    rst_n = 1'b0;
    #1;
    for (int u = 0; u < 3; u += 2) begin
      chk("rst_abort", 64'({ov[u], bz[u], ri[u]}), 64'd0);
      chk("rst_abort_out", o[u], 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release", 64'({ov[0], ir[0], bz[0], ri[0]}), 64'b0100000);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      seen = seen | (|ov) | (|bz);
      @(negedge clk);
    end
    chk("no_partial", 64'(seen), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
